hsci_link_sequencer: RTL

- Bring-up and supervision controller for the HSCI PHY/PLL path that feeds the HSCI master.
- Drives the PLL reset, then waits in order for PLL lock, reset-sequence done and the four BITSLICE ready flags, each wait with a timeout.
- Reports link ready/fail status to the register map and software.
- Monitors lock while up; loss of lock is a reportable failure.

---
 rtl/hsci_link_sequencer_if.sv | 36 +++
 rtl/hsci_link_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hsci_link_sequencer_if.sv
// Handshake and status bundle between the HSCI link sequencer, its controller and the PHY/PLL.
// The sequencer connects through the slave modport; the driving side connects through master.
interface hsci_link_sequencer_if;
    logic       start;
    logic       abort;
    logic       hsci_pll_reset;
    logic       hsci_pll_locked;
    logic       hsci_rst_seq_done;
    logic       hsci_vtc_rdy_bsc_tx;
    logic       hsci_dly_rdy_bsc_tx;
    logic       hsci_vtc_rdy_bsc_rx;
    logic       hsci_dly_rdy_bsc_rx;
    logic       link_ready;
    logic       link_fail;
    logic [2:0] fail_code;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    modport slave (
        input  start, abort,
        input  hsci_pll_locked, hsci_rst_seq_done,
        input  hsci_vtc_rdy_bsc_tx, hsci_dly_rdy_bsc_tx,
        input  hsci_vtc_rdy_bsc_rx, hsci_dly_rdy_bsc_rx,
        output hsci_pll_reset, link_ready, link_fail,
        output fail_code, retry_cnt, seq_state
    );

    modport master (
        output start, abort,
        output hsci_pll_locked, hsci_rst_seq_done,
        output hsci_vtc_rdy_bsc_tx, hsci_dly_rdy_bsc_tx,
        output hsci_vtc_rdy_bsc_rx, hsci_dly_rdy_bsc_rx,
        input  hsci_pll_reset, link_ready, link_fail,
        input  fail_code, retry_cnt, seq_state
    );
endinterface

// File: rtl/hsci_link_sequencer.sv
// HSCI PHY/PLL bring-up and supervision sequencer with per-phase timeouts and lock monitoring.
// Optional automatic restart after a failure: define HSCI_SEQ_AUTO_RETRY_EN.
module hsci_link_sequencer #(
    parameter int PLL_RST_CYCLES = 64,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int RDY_TIMEOUT    = 65535,
    parameter int MAX_RETRY      = 3,
    parameter int SYNC_STAGES    = 2
) (
    input logic                  s_axi_aclk,
    input logic                  s_axi_areset,
    hsci_link_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_WAIT_SEQ  = 3'd3,
        ST_WAIT_BSC  = 3'd4,
        ST_READY     = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    localparam int TMR_MAX = (LOCK_TIMEOUT > RDY_TIMEOUT)
        ? ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES)
        : ((RDY_TIMEOUT > PLL_RST_CYCLES) ? RDY_TIMEOUT : PLL_RST_CYCLES);
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] PLL_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RDY_LAST  = TMR_W'(RDY_TIMEOUT - 1);

    // A 2-bit counter cannot represent more than three retries.
    localparam logic [1:0] RETRY_LIMIT = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);
`ifdef HSCI_SEQ_AUTO_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic [5:0]       sync_r [SYNC_STAGES];
    state_t           state_r;
    state_t           state_nxt_s;
    state_t           seq_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [2:0]       fail_code_r;
    logic [2:0]       fail_code_nxt_s;
    logic [1:0]       retry_cnt_r;
    logic [1:0]       retry_nxt_s;
    logic             pll_reset_r;
    logic             link_ready_r;
    logic             link_fail_r;
    logic [2:0]       seq_state_r;
    logic             lock_s;
    logic             seq_done_s;
    logic             bsc_rdy_s;
    logic             fail_s;
    logic [2:0]       cause_s;
    logic             clr_s;
    logic             retry_ok_s;

    // Status input synchroniser chains; bit 0 lock, bit 1 seq done, bits 5:2 BITSLICE flags.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 6'd0;
            end
        end else begin
            sync_r[0] <= {bus.hsci_dly_rdy_bsc_rx, bus.hsci_vtc_rdy_bsc_rx,
                          bus.hsci_dly_rdy_bsc_tx, bus.hsci_vtc_rdy_bsc_tx,
                          bus.hsci_rst_seq_done, bus.hsci_pll_locked};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign lock_s     = sync_r[SYNC_STAGES-1][0];
    assign seq_done_s = sync_r[SYNC_STAGES-1][1];
    assign bsc_rdy_s  = &sync_r[SYNC_STAGES-1][5:2];
    assign retry_ok_s = RETRY_EN && (retry_cnt_r < RETRY_LIMIT);

    // Next-state, failure detection and fail_code/retry_cnt update.
    always_comb begin
        seq_nxt_s       = state_r;
        fail_s          = 1'b0;
        cause_s         = 3'd0;
        clr_s           = 1'b0;
        state_nxt_s     = state_r;
        fail_code_nxt_s = fail_code_r;
        retry_nxt_s     = retry_cnt_r;

        // Success is checked before the timeout so a same-cycle tie succeeds.
        case (state_r)
            ST_IDLE, ST_FAIL: begin
                if (bus.start) begin
                    seq_nxt_s = ST_PLL_RST;
                    clr_s     = 1'b1;
                end else begin
                    seq_nxt_s = state_r;
                end
            end
            ST_PLL_RST: begin
                if (timer_r == PLL_LAST) begin
                    seq_nxt_s = ST_WAIT_LOCK;
                end else begin
                    seq_nxt_s = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    seq_nxt_s = ST_WAIT_SEQ;
                end else if (timer_r == LOCK_LAST) begin
                    fail_s  = 1'b1;
                    cause_s = 3'd1;
                end else begin
                    seq_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_SEQ: begin
                if (seq_done_s) begin
                    seq_nxt_s = ST_WAIT_BSC;
                end else if (timer_r == RDY_LAST) begin
                    fail_s  = 1'b1;
                    cause_s = 3'd2;
                end else begin
                    seq_nxt_s = ST_WAIT_SEQ;
                end
            end
            ST_WAIT_BSC: begin
                if (bsc_rdy_s) begin
                    seq_nxt_s = ST_READY;
                end else if (timer_r == RDY_LAST) begin
                    fail_s  = 1'b1;
                    cause_s = 3'd3;
                end else begin
                    seq_nxt_s = ST_WAIT_BSC;
                end
            end
            ST_READY: begin
                if (!lock_s) begin
                    fail_s  = 1'b1;
                    cause_s = 3'd4;
                end else begin
                    seq_nxt_s = ST_READY;
                end
            end
            default: begin
                seq_nxt_s = ST_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_nxt_s     = ST_IDLE;
            fail_code_nxt_s = fail_code_r;
            retry_nxt_s     = retry_cnt_r;
        end else if (fail_s && retry_ok_s) begin
            state_nxt_s     = ST_PLL_RST;
            fail_code_nxt_s = cause_s;
            retry_nxt_s     = retry_cnt_r + 2'd1;
        end else if (fail_s) begin
            state_nxt_s     = ST_FAIL;
            fail_code_nxt_s = cause_s;
            retry_nxt_s     = retry_cnt_r;
        end else begin
            state_nxt_s     = seq_nxt_s;
            fail_code_nxt_s = clr_s ? 3'd0 : fail_code_r;
            retry_nxt_s     = clr_s ? 2'd0 : retry_cnt_r;
        end
    end

    // State, phase timer and registered status outputs.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TMR_W{1'b0}};
            fail_code_r  <= 3'd0;
            retry_cnt_r  <= 2'd0;
            pll_reset_r  <= 1'b1;
            link_ready_r <= 1'b0;
            link_fail_r  <= 1'b0;
            seq_state_r  <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            fail_code_r <= fail_code_nxt_s;
            retry_cnt_r <= retry_nxt_s;
            // Timer restarts on every state change and holds at all-ones.
            if (state_nxt_s != state_r) begin
                timer_r <= {TMR_W{1'b0}};
            end else if (timer_r == {TMR_W{1'b1}}) begin
                timer_r <= timer_r;
            end else begin
                timer_r <= timer_r + TMR_W'(1);
            end
            pll_reset_r  <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_PLL_RST) ||
                            (state_nxt_s == ST_FAIL);
            link_ready_r <= (state_nxt_s == ST_READY);
            link_fail_r  <= (state_nxt_s == ST_FAIL);
            seq_state_r  <= state_nxt_s;
        end
    end

    assign bus.hsci_pll_reset = pll_reset_r;
    assign bus.link_ready     = link_ready_r;
    assign bus.link_fail      = link_fail_r;
    assign bus.fail_code      = fail_code_r;
    assign bus.retry_cnt      = retry_cnt_r;
    assign bus.seq_state      = seq_state_r;

endmodule
